// File: rtl/alarm_ctrl.sv
// Purpose: alarm-clock sequencer (idle / ringing / snoozed) driven by a 1 Hz tick.
// Latency: one slowclk edge from sampled inputs to registered outputs.
// Backpressure: none; level inputs are sampled on every slowclk rising edge.
//
// Ports:
//   slowclk      1 Hz tick, rising edge active
//   reset        asynchronous, active-high
//   H_NOW/M_NOW/S_NOW  current time of day (hh 0..23, mm 0..59, ss 0..59)
//   AL_H/AL_M    alarm time; out-of-range values never match
//   arm          level, 1 = alarm enabled; 0 forces IDLE
//   stop         level, cancels the current alarm event
//   snooze       level, requests a snooze while ringing
//   RING         registered, high while RINGING
//   ALM_STATE    registered state code: IDLE=00, RINGING=01, SNOOZED=10
//   SNOOZE_LEFT  registered, snoozes still permitted in the current event
//
// Build option: define ALARM_SNOOZE_EN to enable the SNOOZED state and the
// snooze input. Without it snooze is ignored and SNOOZE_LEFT reads 0.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int SNOOZE_MAX  = 3
) (
  input  logic       slowclk,
  input  logic       reset,
  input  logic [4:0] H_NOW,
  input  logic [5:0] M_NOW,
  input  logic [5:0] S_NOW,
  input  logic [4:0] AL_H,
  input  logic [5:0] AL_M,
  input  logic       arm,
  input  logic       stop,
  input  logic       snooze,
  output logic       RING,
  output logic [1:0] ALM_STATE,
  output logic [1:0] SNOOZE_LEFT
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RINGING = 2'b01,
    ST_SNOOZED = 2'b10
  } state_t;

  // Counters are loaded with N-1 so that the state lasts exactly N edges.
  localparam logic [8:0] RING_LOAD   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] SNZ_FULL    = 2'(SNOOZE_MAX);

  state_t     state, state_nxt;
  logic [8:0] cnt, cnt_nxt;
  logic       ring_q;
  logic       match;

  // Out-of-range alarm settings are excluded explicitly so they can never
  // alias onto a legal time.
  assign match = (AL_H <= 5'd23) && (AL_M <= 6'd59) &&
                 (H_NOW == AL_H) && (M_NOW == AL_M) && (S_NOW == 6'd0);

`ifdef ALARM_SNOOZE_EN
  logic [1:0] left, left_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef ALARM_SNOOZE_EN
    left_nxt  = left;
`endif
    if (!arm) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 9'd0;
`ifdef ALARM_SNOOZE_EN
      left_nxt  = SNZ_FULL;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // stop held across hh:mm:00 suppresses this alarm event entirely
          if (!stop && match) begin
            state_nxt = ST_RINGING;
            cnt_nxt   = RING_LOAD;
`ifdef ALARM_SNOOZE_EN
            left_nxt  = SNZ_FULL;
`endif
          end
        end
        ST_RINGING: begin
          if (stop) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 9'd0;
`ifdef ALARM_SNOOZE_EN
            left_nxt  = SNZ_FULL;
          end else if (snooze && (left != 2'd0)) begin
            state_nxt = ST_SNOOZED;
            cnt_nxt   = SNOOZE_LOAD;
            left_nxt  = left - 2'd1;
`endif
          end else if (cnt == 9'd0) begin
            // auto-off; match is ignored here so no immediate re-trigger
            state_nxt = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
            left_nxt  = SNZ_FULL;
`endif
          end else begin
            cnt_nxt = cnt - 9'd1;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZED: begin
          // a held snooze level is ignored here, so it costs at most one
          // snooze per entry into RINGING
          if (stop) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 9'd0;
            left_nxt  = SNZ_FULL;
          end else if (cnt == 9'd0) begin
            state_nxt = ST_RINGING;
            cnt_nxt   = RING_LOAD;
          end else begin
            cnt_nxt = cnt - 9'd1;
          end
        end
`endif
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 9'd0;
        end
      endcase
    end
  end

  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 9'd0;
      ring_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ring_q <= (state_nxt == ST_RINGING);
    end
  end

  assign RING      = ring_q;
  assign ALM_STATE = state;

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge slowclk or posedge reset) begin
    if (reset) begin
      left <= SNZ_FULL;
    end else begin
      left <= left_nxt;
    end
  end

  assign SNOOZE_LEFT = left;
`else
  logic unused_snooze;
  assign unused_snooze = ^{snooze, SNOOZE_LOAD, SNZ_FULL};
  assign SNOOZE_LEFT   = 2'd0;
`endif

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60, ring duration in slowclk ticks before auto-off (legal 1..511).
REQ-002 SHALL have parameter SNOOZE_SECS, default 300, snooze interval in slowclk ticks (legal 1..511).
REQ-003 SHALL have parameter SNOOZE_MAX, default 3, maximum snoozes per alarm event (legal 0..3).
REQ-004 slowclk  input  1  one clock, 1 Hz tick, rising edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 H_NOW  input  5  current hour 0..23, registered upstream on slowclk.
REQ-007 M_NOW  input  6  current minute 0..59.
REQ-008 S_NOW  input  6  current second 0..59.
REQ-009 AL_H  input  5  alarm hour; values >23 never match.
REQ-010 AL_M  input  6  alarm minute; values >59 never match.
REQ-011 arm  input  1  level; 1 = alarm enabled.
REQ-012 stop  input  1  level, sampled each edge; cancels current alarm event.
REQ-013 snooze  input  1  level, sampled each edge; requests snooze while ringing.
REQ-014 RING  output  1  registered; 1 while in RINGING.
REQ-015 ALM_STATE  output  2  registered state code: IDLE=00, RINGING=01, SNOOZED=10; 11 never driven.
REQ-016 SNOOZE_LEFT  output  2  registered; snoozes still permitted in current event.

Function
REQ-017 match SHALL be (H_NOW==AL_H) && (M_NOW==AL_M) && (S_NOW==0), evaluated combinationally on current inputs.
REQ-018 Priority at every edge SHALL be: arm=0 > stop > snooze > counter expiry > match.
REQ-019 arm=0 SHALL force IDLE, RING=0, counter=0, SNOOZE_LEFT=SNOOZE_MAX at the next edge from any state.
REQ-020 IDLE: arm=1 && match SHALL go to RINGING at the next edge, load counter RING_SECS-1, load SNOOZE_LEFT=SNOOZE_MAX; RING rises exactly one slowclk after the edge at which time reads hh:mm:00.
REQ-021 IDLE with stop=1 or snooze=1 and no match SHALL remain IDLE; stop=1 with match SHALL block entry (stays IDLE).
REQ-022 RINGING: stop=1 SHALL go to IDLE, RING=0 next edge.
REQ-023 RINGING: snooze=1 && SNOOZE_LEFT>0 SHALL go to SNOOZED, load counter SNOOZE_SECS-1, decrement SNOOZE_LEFT; with SNOOZE_LEFT=0 snooze SHALL be ignored.
REQ-024 RINGING: counter==0 SHALL go to IDLE (auto-off); otherwise counter decrements by 1 per edge.
REQ-025 SNOOZED: stop=1 SHALL go to IDLE; counter==0 SHALL go to RINGING reloading RING_SECS-1; otherwise counter decrements; snooze input ignored.
REQ-026 match SHALL be ignored in RINGING and SNOOZED (no restart, no counter reload).
REQ-027 Counter SHALL be 9 bits unsigned, never wrap below 0, never exceed 511.
REQ-028 A held snooze level SHALL consume at most one snooze per RINGING entry (it is ignored in SNOOZED).
REQ-029 After auto-off at midnight-spanning times no rearm SHALL occur until the next match at hh:mm:00 (24 h later for unchanged AL_H/AL_M).

Reset
REQ-030 reset=1 SHALL immediately force ALM_STATE=00, RING=0, counter=0, SNOOZE_LEFT=SNOOZE_MAX, regardless of slowclk, including mid-ring or mid-snooze.
REQ-031 First evaluation after reset release SHALL occur at the next slowclk rising edge; no pending event survives reset.

Configuration
REQ-032 Macro ALARM_SNOOZE_EN: defined SHALL implement SNOOZED state and snooze input per REQ-023/025.
REQ-033 Without ALARM_SNOOZE_EN: snooze input SHALL be ignored, SNOOZED never entered, SNOOZE_LEFT tied 0, all other behaviour unchanged.

Verification
REQ-034 AL=07:30, arm=1, time steps 07:29:59 -> 07:30:00 -> RING=1, ALM_STATE=01 one edge after 07:30:00 seen.
REQ-035 Ringing, no inputs, RING_SECS=60 -> RING high for exactly 60 edges, then ALM_STATE=00.
REQ-036 Ringing, snooze pulse 1 edge, SNOOZE_SECS=300 -> RING=0, SNOOZE_LEFT=2, RING returns after 300 edges; 4th snooze with SNOOZE_LEFT=0 ignored.
REQ-037 Ringing, stop and snooze both 1 same edge -> ALM_STATE=00, SNOOZE_LEFT=3.
REQ-038 Mid-snooze, assert reset between edges -> outputs 00/0/3 immediately; arm=0 during RINGING -> IDLE next edge.
REQ-039 AL_H=24 or AL_M=60, run full 24 h -> RING never asserts.
